dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the pipelined datapath's Memory stage. Receives
//  word read/write requests (ALUOutM address, WriteDataM data) and returns
//  ReadData after a parameterised number of wait states.
//  Drives StallM back to the pipeline while a request is outstanding.
// PARAMETERS
//  DEPTH_WORDS  64  storage depth in 32-bit words; power of two, >= 4
//  WAIT_STATES  2   extra cycles between accept and response; 0..15
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   synchronous, active-high
//  MemReqM     in   1   request valid; held high by the requester until MemDoneM
//  MemWriteM   in   1   1 = write, 0 = read; sampled at accept
//  ALUOutM     in   32  byte address; sampled at accept
//  WriteDataM  in   32  write data; sampled at accept
//  ReadData    out  32  read data; valid while MemDoneM=1, held until next accept
//  MemDoneM    out  1   one-cycle response strobe
//  StallM      out  1   combinational: MemReqM & ~MemDoneM
//  MemErrM     out  1   misalignment error, qualified by MemDoneM (see CONFIGURATION)
// BEHAVIOUR
//  - States: IDLE, WAIT, RESP.
//  - Reset values: state=IDLE, wait counter=0, ReadData=0, MemDoneM=0, MemErrM=0.
//    Storage contents are not reset.
//  - IDLE: if MemReqM=1, capture MemWriteM, ALUOutM and WriteDataM. Go to WAIT if
//    WAIT_STATES>0, else go to RESP. Load counter=WAIT_STATES-1.
//  - WAIT: decrement counter each cycle; at 0 go to RESP. Live inputs are
//    ignored; only the captured copy is used.
//  - RESP: MemDoneM=1 for exactly one cycle, then IDLE. MemReqM is ignored in
//    RESP, so back-to-back requests are spaced by one IDLE cycle minimum.
//  - Latency: accept at cycle 0, MemDoneM at cycle WAIT_STATES+1.
//  - Read: word index = addr[log2(DEPTH_WORDS)+1:2]. ReadData is registered on
//    the edge that enters RESP. Upper address bits alias (wrap-around).
//  - Write: committed on the edge that enters RESP. ReadData returns the newly
//    written word (write-first).
//  - addr[1:0] is ignored unless DMEM_MISALIGN_TRAP_EN is defined.
//  - Reset mid-operation: return to IDLE and discard any pending write.
//    No MemDoneM is issued for the aborted request.
//  - MemReqM deasserted while in WAIT: the access still completes and MemDoneM
//    still pulses (protocol violation, tolerated).
// CONFIGURATION
//  DMEM_MISALIGN_TRAP_EN
//   - Defined: if captured addr[1:0]!=0, the write is suppressed, ReadData=0 and
//     MemErrM=1 in the RESP cycle. Timing is unchanged.
//   - Undefined: MemErrM is tied 0 and addr[1:0] is ignored.
// STRUCTURE
//  - dmem_pkg: state enum (IDLE/WAIT/RESP) and a clog2-based index-width
//    localparam helper.
//  - Sub-module dmem_ram: DEPTH_WORDS x 32 array with synchronous write and a
//    registered read port.
//  - The FSM, counter and capture registers live in dmem_responder.
// TESTING
//  1. Reset, then hold MemReqM=0 -> ReadData=0, MemDoneM=0, StallM=0 every cycle.
//  2. WAIT_STATES=2: write 0xDEADBEEF @0x10 at cycle 0 -> MemDoneM at cycle 3
//     only, StallM=1 cycles 0-2. Then read @0x10 -> 0xDEADBEEF at MemDoneM.
//  3. WAIT_STATES=0: read @0x4 -> MemDoneM the cycle after accept.
//     A held request is re-accepted only after an IDLE cycle.
//  4. DEPTH_WORDS=64: write 0x1 @0x100 -> read @0x0 returns 0x1 (alias).
//  5. Assert reset during WAIT of a write 0x55 @0x8 -> no MemDoneM;
//     a later read @0x8 returns the old value.
//  6. Macro defined: write @0x6 -> MemErrM=1 with MemDoneM, memory unchanged.
//     Macro undefined: same stimulus writes word 1 and MemErrM=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM state encoding and index-width helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Wide enough for WAIT_STATES up to 15
  localparam int CNT_W = 4;

  function automatic int idx_w(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Memory-stage request/response bundle between the pipeline and the data-memory responder.
interface dmem_responder_if;

  logic        MemReqM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadData;
  logic        MemDoneM;
  logic        StallM;
  logic        MemErrM;

  modport master (
    output MemReqM, MemWriteM, ALUOutM, WriteDataM,
    input  ReadData, MemDoneM, StallM, MemErrM
  );

  modport slave (
    input  MemReqM, MemWriteM, ALUOutM, WriteDataM,
    output ReadData, MemDoneM, StallM, MemErrM
  );

endinterface

// File: rtl/dmem_ram.sv
// DEPTH_WORDS x 32 storage with synchronous write and a registered, write-first read port.
module dmem_ram #(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             we,
  input  logic             clr,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= wdata;
    end
  end

  // Read register holds its value between accesses
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (en) begin
      if (clr) begin
        rdata <= '0;
      end else if (we) begin
        rdata <= wdata;
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the Memory stage: accepts one word request, waits WAIT_STATES cycles,
// then pulses MemDoneM. Optional misalignment trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus
);

  localparam int IDX_W = idx_w(DEPTH_WORDS);
  localparam int AW    = IDX_W + 2;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             go_resp;

  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [31:0]      wdata_q;

  logic             acc_we;
  logic [AW-1:0]    acc_addr;
  logic [31:0]      acc_wdata;
  logic             acc_bad;
  logic             ram_en;
  logic [31:0]      ram_rdata;
  logic             unused_bits;

  // Control state
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request capture: data only, no reset needed
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.MemReqM) begin
      we_q    <= bus.MemWriteM;
      addr_q  <= bus.ALUOutM[AW-1:0];
      wdata_q <= bus.WriteDataM;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    go_resp   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.MemReqM) begin
          if (WAIT_STATES > 0) begin
            cnt_nxt   = CNT_W'(WAIT_STATES - 1);
            state_nxt = WAIT;
          end else begin
            cnt_nxt   = '0;
            state_nxt = RESP;
            go_resp   = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
          go_resp   = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // With zero wait states the access happens on the accept edge, before the capture registers load
  always_comb begin
    if (state == IDLE) begin
      acc_we    = bus.MemWriteM;
      acc_addr  = bus.ALUOutM[AW-1:0];
      acc_wdata = bus.WriteDataM;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q;

  assign acc_bad = |acc_addr[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (go_resp) begin
      err_q <= acc_bad;
    end
  end

  assign bus.MemErrM = (state == RESP) & err_q;
`else
  assign acc_bad     = 1'b0;
  assign bus.MemErrM = 1'b0;
`endif

  // Reset wins over a completing access so an aborted write never lands
  assign ram_en = go_resp & ~reset;

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst   (reset),
    .en    (ram_en),
    .we    (acc_we & ~acc_bad),
    .clr   (acc_bad),
    .idx   (acc_addr[AW-1:2]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  assign bus.ReadData = ram_rdata;
  assign bus.MemDoneM = (state == RESP);
  assign bus.StallM   = bus.MemReqM & ~bus.MemDoneM;

  // Upper address bits alias; byte offset only matters with the trap enabled
  assign unused_bits = ^{bus.ALUOutM[31:AW], acc_addr[1:0]};

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with WAIT_STATES=2, one with WAIT_STATES=0.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset;
  logic use0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder_if i2 ();
  dmem_responder_if i0 ();

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(2)) u_ws2 (
    .clk   (clk),
    .reset (reset),
    .bus   (i2.slave)
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u_ws0 (
    .clk   (clk),
    .reset (reset),
    .bus   (i0.slave)
  );

  logic [31:0] o_rd;
  logic        o_done, o_stall, o_err;

  assign o_rd    = use0 ? i0.ReadData : i2.ReadData;
  assign o_done  = use0 ? i0.MemDoneM : i2.MemDoneM;
  assign o_stall = use0 ? i0.StallM   : i2.StallM;
  assign o_err   = use0 ? i0.MemErrM  : i2.MemErrM;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (use0) begin
      i0.MemReqM = req; i0.MemWriteM = we; i0.ALUOutM = a; i0.WriteDataM = d;
    end else begin
      i2.MemReqM = req; i2.MemWriteM = we; i2.ALUOutM = a; i2.WriteDataM = d;
    end
  endtask

  // Starts at posedge+#1 with the DUT in IDLE; ends one posedge after the MemDoneM cycle
  task automatic xact(input string tag, input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int lat;
    lat = -1;
    drive(1'b1, we, a, d);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) chk({tag, "_stall_accept"}, 32'(o_stall), 32'd1);
      if (o_done) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_rdata"}, o_rd, exp_rd);
    chk({tag, "_err"}, 32'(o_err), 32'(exp_err));
    chk({tag, "_stall_done"}, 32'(o_stall), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic exp_pat [4];
    exp_pat[0] = 1'b0; exp_pat[1] = 1'b1; exp_pat[2] = 1'b0; exp_pat[3] = 1'b1;

    reset = 1'b1;
    use0  = 1'b0;
    i2.MemReqM = 1'b0; i2.MemWriteM = 1'b0; i2.ALUOutM = '0; i2.WriteDataM = '0;
    i0.MemReqM = 1'b0; i0.MemWriteM = 1'b0; i0.ALUOutM = '0; i0.WriteDataM = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("idle_ws2_rd", i2.ReadData, 32'h0);
      chk("idle_ws2_done", 32'(i2.MemDoneM), 32'd0);
      chk("idle_ws2_stall", 32'(i2.StallM), 32'd0);
      chk("idle_ws0_rd", i0.ReadData, 32'h0);
      chk("idle_ws0_done", 32'(i0.MemDoneM), 32'd0);
      chk("idle_ws0_stall", 32'(i0.StallM), 32'd0);
    end
    @(posedge clk); #1;

    // Two wait states: write then read back
    use0 = 1'b0;
    xact("ws2_wr10", 1'b1, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3);
    xact("ws2_rd10", 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3);

    // Reset during WAIT discards the pending write
    xact("ws2_wr08", 1'b1, 32'h08, 32'h00000011, 32'h00000011, 1'b0, 3);
    drive(1'b1, 1'b1, 32'h08, 32'h00000055);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(o_done), 32'd0);
      chk("abort_rd_reset", o_rd, 32'h0);
    end
    @(posedge clk); #1;
    xact("ws2_rd08_old", 1'b0, 32'h08, 32'h0, 32'h00000011, 1'b0, 3);

    // Misaligned write
    xact("ws2_wr04", 1'b1, 32'h04, 32'h12345678, 32'h12345678, 1'b0, 3);
`ifdef DMEM_MISALIGN_TRAP_EN
    xact("ws2_wr06_trap", 1'b1, 32'h06, 32'hCAFE0001, 32'h0, 1'b1, 3);
    xact("ws2_rd04_kept", 1'b0, 32'h04, 32'h0, 32'h12345678, 1'b0, 3);
`else
    xact("ws2_wr06", 1'b1, 32'h06, 32'hCAFE0001, 32'hCAFE0001, 1'b0, 3);
    xact("ws2_rd04_new", 1'b0, 32'h04, 32'h0, 32'hCAFE0001, 1'b0, 3);
`endif

    // Zero wait states
    use0 = 1'b1;
    xact("ws0_wr04", 1'b1, 32'h04, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1);
    xact("ws0_rd04", 1'b0, 32'h04, 32'h0,        32'hA5A5A5A5, 1'b0, 1);

    // Held request: accept, done, idle re-accept, done
    drive(1'b1, 1'b0, 32'h04, 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("ws0_held_done_c%0d", c), 32'(o_done), 32'(exp_pat[c]));
      if (exp_pat[c]) chk($sformatf("ws0_held_rd_c%0d", c), o_rd, 32'hA5A5A5A5);
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;

    // Address aliasing with 64 words
    xact("ws0_wr100", 1'b1, 32'h100, 32'h00000001, 32'h00000001, 1'b0, 1);
    xact("ws0_rd000", 1'b0, 32'h000, 32'h0,        32'h00000001, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
